dot_prod_seq: RTL

Sequencer for the multiply-accumulate datapath. Computes one unsigned dot product per job.
- Accepts a job (start, len).
- Streams len operand pairs in over a valid/ready handshake.
- Accumulates a*b into a 2*WIDTH accumulator, with the clear and enable driven by its FSM.
- Presents the sum on a valid/ready result port.
- Sits between the operand-fetch logic and the result consumer.

---
 rtl/dot_prod_seq_pkg.sv | 15 +
 rtl/dot_prod_seq_if.sv | 31 +++
 rtl/dot_prod_seq_mac_acc.sv | 47 ++++
 rtl/dot_prod_seq.sv | 98 +++++++++
 4 files changed

// File: rtl/dot_prod_seq_pkg.sv
// Shared types and width helpers for the dot-product sequencer.
// DOT_PROD_SEQ_SAT_EN (optional) selects accumulator saturation in mac_acc.
package dot_prod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ACC_W(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/dot_prod_seq_if.sv
// Job, operand-stream and result handshake bundle for dot_prod_seq.
// DOT_PROD_SEQ_SAT_EN has no effect on this interface.
interface dot_prod_seq_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
);
  import dot_prod_pkg::*;

  logic                      start;
  logic [LEN_W-1:0]          len;
  logic                      abort;
  logic                      busy;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          a_in;
  logic [WIDTH-1:0]          b_in;
  logic                      res_valid;
  logic                      res_ready;
  logic [ACC_W(WIDTH)-1:0]   res_data;
  logic                      ovf;

  modport master (
    output start, len, abort, in_valid, a_in, b_in, res_ready,
    input  busy, in_ready, res_valid, res_data, ovf
  );

  modport slave (
    input  start, len, abort, in_valid, a_in, b_in, res_ready,
    output busy, in_ready, res_valid, res_data, ovf
  );
endinterface

// File: rtl/dot_prod_seq_mac_acc.sv
// Unsigned multiply-accumulate with sticky carry-out flag.
// Define DOT_PROD_SEQ_SAT_EN to clamp the accumulator to all-ones on carry.
module mac_acc
  import dot_prod_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  output logic [ACC_W(WIDTH)-1:0] acc,
  output logic                    ovf
);
  localparam int AW = ACC_W(WIDTH);

  logic [AW-1:0] prod;
  logic [AW:0]   sum;

  function automatic logic [AW-1:0] sat_add(input logic [AW:0] s);
`ifdef DOT_PROD_SEQ_SAT_EN
    return s[AW] ? {AW{1'b1}} : s[AW-1:0];
`else
    return s[AW-1:0];
`endif
  endfunction

  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  // One spare bit on the adder exposes the carry that drives ovf.
  assign sum  = {1'b0, acc} + {1'b0, prod};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= sat_add(sum);
      ovf <= ovf | sum[AW];
    end
  end

endmodule

// File: rtl/dot_prod_seq.sv
// Job sequencer around mac_acc: accepts (start,len), streams len operand pairs, returns the sum.
// DOT_PROD_SEQ_SAT_EN is passed through to mac_acc (saturating accumulation).
module dot_prod_seq
  import dot_prod_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input logic           clk,
  input logic           reset,
  dot_prod_seq_if.slave bus
);
  localparam int AW = ACC_W(WIDTH);

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic              accept;
  logic              beat;
  logic              last;
  logic              acc_clr;
  logic              acc_en;
  logic [AW-1:0]     acc;
  logic              ovf;

  assign accept = (state == IDLE) && bus.start;
  assign beat   = bus.in_valid && bus.in_ready;
  assign last   = (cnt == len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.len != '0) ? RUN : DONE;
      RUN: begin
        if (bus.abort)         state_nxt = IDLE;
        else if (beat && last) state_nxt = DONE;
      end
      DONE: begin
        if (bus.abort || bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // abort suppresses the same-cycle beat so acc holds the pre-abort value.
  always_comb begin
    bus.busy      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.res_valid = 1'b0;
    acc_clr       = 1'b0;
    acc_en        = 1'b0;
    case (state)
      IDLE: acc_clr = bus.start;
      RUN: begin
        bus.busy     = 1'b1;
        bus.in_ready = 1'b1;
        acc_en       = bus.in_valid && !bus.abort;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      len_q <= '0;
    end else if (accept) begin
      cnt   <= '0;
      len_q <= bus.len;
    end else if (acc_en) begin
      cnt   <= cnt + LEN_W'(1);
    end
  end

  mac_acc #(.WIDTH(WIDTH)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr),
    .en    (acc_en),
    .a     (bus.a_in),
    .b     (bus.b_in),
    .acc   (acc),
    .ovf   (ovf)
  );

  assign bus.res_data = acc;
  assign bus.ovf      = ovf;

endmodule
